// File: rtl/led_racer_pkg.sv
// Shared types and helpers for the LED racer screens.
package led_racer_pkg;

  localparam int PLAYER_ID_W = 3;

  typedef enum logic [1:0] {
    ES_ARMED,
    ES_BLINK,
    ES_SOLID
  } es_state_t;

  // Palette lookup, returned packed as {green, red, blue}.
  function automatic logic [23:0] player_colour(input logic [PLAYER_ID_W-1:0] id,
                                                input logic [7:0]             intensity);
    logic [7:0] lit;
    logic [7:0] dim;
    lit = intensity;
    dim = intensity >> 1;
    case (id)
      3'd0:    player_colour = {lit,   8'd0,  8'd0};
      3'd1:    player_colour = {8'd0,  lit,   8'd0};
      3'd2:    player_colour = {8'd0,  8'd0,  lit};
      3'd3:    player_colour = {lit,   lit,   8'd0};
      3'd4:    player_colour = {lit,   8'd0,  lit};
      3'd5:    player_colour = {8'd0,  lit,   lit};
      3'd6:    player_colour = {lit,   lit,   lit};
      default: player_colour = {dim,   dim,   dim};
    endcase
  endfunction

endpackage

// File: rtl/end_screen_latched_blink_timer.sv
// Blink sequencer: equal ON/OFF half-periods, counts OFF phases, flags the end.
module blink_timer #(
  parameter int unsigned BLINK_DIV   = 6_000_000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic phase,
  output logic done
);

  localparam int DIV_W = $clog2(BLINK_DIV);
  localparam int CNT_W = (BLINK_COUNT == 0) ? 1 : $clog2(BLINK_COUNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_COUNT);

  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] blinks_q;
  logic             phase_q;
  logic             running_q;
  logic             terminal;

  assign terminal = running_q && (div_q == DIV_LAST);
  assign done     = terminal && !phase_q && (blinks_q == CNT_LAST);
  assign phase    = phase_q;

  // Divider, phase toggle and saturating blink counter; start re-arms from ON.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      blinks_q  <= '0;
      phase_q   <= 1'b1;
      running_q <= 1'b0;
    end else if (clear) begin
      div_q     <= '0;
      blinks_q  <= '0;
      phase_q   <= 1'b1;
      running_q <= 1'b0;
    end else if (start) begin
      div_q     <= '0;
      blinks_q  <= '0;
      phase_q   <= 1'b1;
      running_q <= 1'b1;
    end else if (running_q) begin
      if (terminal) begin
        div_q   <= '0;
        phase_q <= ~phase_q;
        if (done) begin
          running_q <= 1'b0;
        end
        if (phase_q && (blinks_q != CNT_LAST)) begin
          blinks_q <= blinks_q + CNT_W'(1);
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/pipe_tri_bus.sv
// Shared LED bus stage: a screen either drives the bus or passes upstream through.
module pipe_tri_bus (
  input  logic       enable,
  input  logic [7:0] screen_red,
  input  logic [7:0] screen_green,
  input  logic [7:0] screen_blue,
  input  logic [7:0] i_red_intensity,
  input  logic [7:0] i_green_intensity,
  input  logic [7:0] i_blue_intensity,
  output logic [7:0] o_red_intensity,
  output logic [7:0] o_green_intensity,
  output logic [7:0] o_blue_intensity
);

  assign o_red_intensity   = enable ? screen_red   : i_red_intensity;
  assign o_green_intensity = enable ? screen_green : i_green_intensity;
  assign o_blue_intensity  = enable ? screen_blue  : i_blue_intensity;

endmodule

// File: rtl/end_screen_latched.sv
// End-of-race screen: latches the first finisher and blinks then holds its colour.
module end_screen_latched
  import led_racer_pkg::*;
#(
  parameter int unsigned MAX_POS     = 109,
  parameter int unsigned PLAYERS     = 4,
  parameter logic [7:0]  INTENSITY   = 8'd5,
  parameter int unsigned BLINK_DIV   = 6_000_000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   enable,
  input  logic                                   clear,
  input  logic [PLAYERS*$clog2(MAX_POS)-1:0]     positions,
  input  logic [7:0]                             i_red_intensity,
  input  logic [7:0]                             i_blue_intensity,
  input  logic [7:0]                             i_green_intensity,
  output logic [7:0]                             o_red_intensity,
  output logic [7:0]                             o_blue_intensity,
  output logic [7:0]                             o_green_intensity,
  output logic                                   winner_valid,
  output logic [PLAYER_ID_W-1:0]                 winner_id
);

  localparam int unsigned PW = $clog2(MAX_POS);
  localparam logic [PW-1:0] FINISH = PW'(MAX_POS - 1);

  es_state_t              state_q;
  es_state_t              state_d;
  logic                   hit;
  logic [PLAYER_ID_W-1:0] hit_id;
  logic                   latch;
  logic                   timer_start;
  logic                   timer_phase;
  logic                   timer_done;
  logic [PLAYER_ID_W-1:0] winner_id_q;
  logic [23:0]            palette;
  logic [23:0]            screen;

  // Lowest-index racer sitting on the finish LED wins a simultaneous arrival.
  always_comb begin
    hit    = 1'b0;
    hit_id = '0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      if (!hit && (positions[p*PW +: PW] == FINISH)) begin
        hit    = 1'b1;
        hit_id = PLAYER_ID_W'(p);
      end
    end
  end

  // Next-state logic; clear overrides any finish seen in the same cycle.
  always_comb begin
    state_d     = state_q;
    latch       = 1'b0;
    timer_start = 1'b0;
    if (clear) begin
      state_d = ES_ARMED;
    end else begin
      case (state_q)
        ES_ARMED: begin
          if (hit) begin
            latch = 1'b1;
            if (BLINK_COUNT == 0) begin
              state_d = ES_SOLID;
            end else begin
              state_d     = ES_BLINK;
              timer_start = 1'b1;
            end
          end
        end
        ES_BLINK: begin
          if (timer_done) begin
            state_d = ES_SOLID;
          end
        end
        ES_SOLID: state_d = ES_SOLID;
        default:  state_d = ES_ARMED;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ES_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Winner latch; only loads on the ARMED cycle that detects a finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_id_q <= '0;
    end else if (clear) begin
      winner_id_q <= '0;
    end else if (latch) begin
      winner_id_q <= hit_id;
    end
  end

  assign winner_valid = (state_q != ES_ARMED);
  assign winner_id    = winner_id_q;

  blink_timer #(
    .BLINK_DIV   (BLINK_DIV),
    .BLINK_COUNT (BLINK_COUNT)
  ) u_blink_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (timer_start),
    .clear (clear),
    .phase (timer_phase),
    .done  (timer_done)
  );

  // Screen colour: dark when armed or in an OFF phase, winner colour otherwise.
  always_comb begin
    palette = player_colour(winner_id_q, INTENSITY);
    screen  = '0;
    case (state_q)
      ES_BLINK: if (timer_phase) screen = palette;
      ES_SOLID: screen = palette;
      default:  screen = '0;
    endcase
  end

  pipe_tri_bus u_bus (
    .enable            (enable),
    .screen_red        (screen[15:8]),
    .screen_green      (screen[23:16]),
    .screen_blue       (screen[7:0]),
    .i_red_intensity   (i_red_intensity),
    .i_green_intensity (i_green_intensity),
    .i_blue_intensity  (i_blue_intensity),
    .o_red_intensity   (o_red_intensity),
    .o_green_intensity (o_green_intensity),
    .o_blue_intensity  (o_blue_intensity)
  );

endmodule

// File: doc/end_screen_latched.md
# end_screen_latched

Parametrised, sequential end-of-race screen driver. Watches the positions of up to `PLAYERS` racers, latches the first racer to reach the finish LED (`MAX_POS-1`), then paints the strip in that racer's colour: a fixed number of blinks, then solid until cleared. Sits in the screen manager beside the other screens. Drives the shared LED intensity bus when `enable` is high and passes the upstream bus through when it is low.

## Interface
Parameters:
- `MAX_POS`, 109: number of LEDs. Finish position is `MAX_POS-1`. `PW = $clog2(MAX_POS)`.
- `PLAYERS`, 4: number of racers, legal range 1..8.
- `INTENSITY`, 8'd5: per-channel level used for a lit colour channel.
- `BLINK_DIV`, 24'd6_000_000: clock cycles per blink half-period, must be ≥ 2.
- `BLINK_COUNT`, 3: number of off-phases before the display goes solid, must be ≥ 0.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: this screen owns the output bus.
- `clear` in 1: synchronous re-arm for a new race.
- `positions` in `PLAYERS*PW`: player p occupies bits `[p*PW +: PW]`.
- `i_red_intensity`, `i_blue_intensity`, `i_green_intensity` in 8 each: upstream bus.
- `o_red_intensity`, `o_blue_intensity`, `o_green_intensity` out 8 each: downstream bus.
- `winner_valid` out 1: a winner is latched.
- `winner_id` out 3: index of the latched winner.

## Operation
FSM states and transitions:
- ARMED: no winner.
  - Each cycle, scan `positions` for `== MAX_POS-1`.
  - The lowest index hit goes to BLINK. This is the tie-break for simultaneous arrivals.
- BLINK:
  - `phase` starts ON. The divider counts `0..BLINK_DIV-1`; at the terminal count `phase` toggles.
  - Each ON→OFF transition increments `blinks`.
  - When the OFF phase that ends with `blinks == BLINK_COUNT` completes, go to SOLID.
  - With `BLINK_COUNT = 0`, go from ARMED straight to SOLID.
- SOLID: colour shown continuously. The FSM holds here until `clear` or reset.

`clear`:
- `clear` high in any state gives ARMED next cycle, with counters zeroed and `winner_valid` low.
- `clear` has priority over a finish detected in the same cycle. That finish is re-evaluated the following cycle.

Latch behaviour:
- Positions changing after the latch do not affect the latched winner.
- `enable` low does not affect the FSM, the latch or the blink counters. Blink timing is free-running.

Colour palette, indexed by player as {G,R,B}, each channel either 0 or `INTENSITY`:
- 0 green {1,0,0}
- 1 red {0,1,0}
- 2 blue {0,0,1}
- 3 yellow {1,1,0}
- 4 cyan {1,0,1}
- 5 magenta {0,1,1}
- 6 white {1,1,1}
- 7 dim white: `INTENSITY>>1` on all channels.

Screen colour:
- ARMED: all channels 0.
- BLINK with `phase` ON, and SOLID: the winner's palette entry.
- BLINK with `phase` OFF: all channels 0.

Bus: `o_* = enable ? screen_colour : i_*`. This path is combinational and has no register.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State ARMED, `winner_valid` = 0, `winner_id` = 0, divider = 0, `blinks` = 0, `phase` = ON.
  - `o_*` = `i_*` if `enable` is low, else 0.
- Latency from detection to display:
  - A finish sampled at edge N gives `winner_valid`/`winner_id` valid after edge N.
  - Coloured output is visible in the same cycle. That is one cycle of latency from the position change.
- First ON phase lasts exactly `BLINK_DIV` cycles. Each subsequent phase also lasts `BLINK_DIV` cycles.
- Total BLINK duration is `2*BLINK_COUNT*BLINK_DIV` cycles, then SOLID.
- Width rules:
  - The divider is `$clog2(BLINK_DIV)` bits and must never exceed `BLINK_DIV-1`.
  - `blinks` is `$clog2(BLINK_COUNT+1)` bits, minimum 1, and saturates and never wraps.
  - Positions ≥ `MAX_POS` are ignored and never treated as a finish.
- Reset asserted mid-BLINK: immediate return to reset values. No partial blink is resumed.

## Structure
- Package `led_racer_pkg`:
  - `PLAYER_ID_W = 3`.
  - A palette function `player_colour(id, intensity)` returning `{g,r,b}` 24 bits.
  - State enum `{ES_ARMED, ES_BLINK, ES_SOLID}`.
- Sub-module `blink_timer`:
  - Parameters: `BLINK_DIV`, `BLINK_COUNT`.
  - Inputs: `clk`, `rst_n`, `start`, `clear`.
  - Outputs: `phase`, `done`.
- The existing `pipe_tri_bus` performs the output mux.
- Top level: winner priority encoder, latch, FSM.

## Test plan
- Reset then idle:
  - `enable=1` and all positions < 108 → outputs 0 and `winner_valid=0`.
  - `enable=0` → `o_*` mirrors `i_*` = (7,9,11).
- Single finish (`BLINK_DIV=4`, `BLINK_COUNT=2`), player 2 = 108 at edge N:
  - `winner_id=2` after N and blue=5.
  - Off after 4 cycles, pattern on/off/on/off of 4 cycles each.
  - Solid blue from cycle N+16 onward.
- Tie: players 1 and 3 both reach 108 in the same cycle → `winner_id=1`, red=5. A later change to player 1's position does not alter it.
- `clear` in BLINK while player 0 = 108 in that same cycle:
  - Next cycle ARMED, outputs 0.
  - Following cycle `winner_id=0`, green=5.
- `rst_n` low mid-BLINK → outputs and flags return to reset values asynchronously, before the next edge.
- `PLAYERS=8`, player 7 finishes → all channels = 2 (`INTENSITY>>1`). `BLINK_COUNT=0` → solid immediately.
